// File: rtl/mem_responder.sv
// mem_responder: single-outstanding 64-bit memory model with fixed response
// latency, byte-lane write masks and address range/alignment checking.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid / req_ready         request handshake (ready only when idle)
//   req_wen, req_addr,
//   req_wdata, req_wmask          request payload, latched on accept
//   resp_valid / resp_ready       response handshake (valid only in RESP)
//   resp_rdata, resp_err          response payload, held stable in RESP
module mem_responder #(
   parameter int unsigned DEPTH_LOG2 = 8,
   parameter int unsigned LATENCY    = 2,
   parameter logic [63:0] BASE       = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wen_q;
   logic [63:0] addr_q, wdata_q;
   logic [7:0]  wmask_q;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [63:0] mem_q [DEPTH];

   logic                  enter_resp;
   logic                  cur_wen;
   logic [63:0]           cur_addr, cur_wdata;
   logic [7:0]            cur_wmask;
   logic [63:0]           word_idx;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  addr_err;

   // With zero latency the transaction completes on the accept edge itself,
   // before the request latches hold it, so IDLE works from the live inputs.
   always_comb begin
      if (state_q == IDLE) begin
         cur_wen   = req_wen;
         cur_addr  = req_addr;
         cur_wdata = req_wdata;
         cur_wmask = req_wmask;
      end else begin
         cur_wen   = wen_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
         cur_wmask = wmask_q;
      end
      word_idx = (cur_addr - BASE) >> 3;
      idx      = word_idx[DEPTH_LOG2-1:0];
      addr_err = (cur_addr < BASE) || ((word_idx >> DEPTH_LOG2) != '0)
                 || (cur_addr[2:0] != 3'b000);
      err_d    = addr_err;
      rdata_d  = (addr_err || cur_wen) ? '0 : mem_q[idx];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (LATENCY == 0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (enter_resp) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == IDLE && req_valid) begin
         wen_q   <= req_wen;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         wmask_q <= req_wmask;
      end
   end

   // Storage is deliberately not reset; a reset only suppresses the commit.
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && cur_wen && !addr_err) begin
         for (int unsigned b = 0; b < 8; b++) begin
            if (cur_wmask[b]) mem_q[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
         end
      end
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder with the
// default parameters (u_dut) and a zero-latency instance (u_dut0).
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_wmask;
   logic        resp_valid, resp_ready, resp_err;
   logic [63:0] resp_rdata;

   logic        req_valid0, req_ready0, req_wen0;
   logic [63:0] req_addr0, req_wdata0;
   logic [7:0]  req_wmask0;
   logic        resp_valid0, resp_ready0, resp_err0;
   logic [63:0] resp_rdata0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_responder u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wmask  (req_wmask),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   mem_responder #(.LATENCY(0)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid0),
      .req_ready  (req_ready0),
      .req_wen    (req_wen0),
      .req_addr   (req_addr0),
      .req_wdata  (req_wdata0),
      .req_wmask  (req_wmask0),
      .resp_valid (resp_valid0),
      .resp_ready (resp_ready0),
      .resp_rdata (resp_rdata0),
      .resp_err   (resp_err0)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction on u_dut; returns once the response is visible and,
   // if resp_ready is high, after the consuming edge.
   task automatic xact(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask, output logic [63:0] rdata,
                       output logic err, output int lat);
      int n;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      req_wmask = wmask;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wen   = ~wen;
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      req_wmask = 8'($urandom);
      lat = 1;
      while (!resp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("resp_seen", 64'(resp_valid), 64'd1);
      rdata = resp_rdata;
      err   = resp_err;
      if (resp_ready) begin
         @(posedge clk); #1;
      end
   endtask

   logic [63:0] rd;
   logic        er;
   int          lat;
   logic        seen;

   logic        op_wen   [4];
   logic [63:0] op_addr  [4];
   logic [63:0] op_wdata [4];
   logic [63:0] op_exp   [4];

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
      resp_ready = 1'b1;
      req_valid0 = 1'b0; req_wen0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_wmask0 = '0;
      resp_ready0 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_req_ready",  64'(req_ready),  64'd1);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_rdata",      resp_rdata,      64'd0);
      check("rst_err",        64'(resp_err),   64'd0);

      // full write then read
      xact(1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, rd, er, lat);
      check("wr_err",   64'(er),  64'd0);
      check("wr_rdata", rd,       64'd0);
      check("wr_lat",   64'(lat), 64'd3);
      xact(1'b0, 64'h8000_0010, 64'h0, 8'h00, rd, er, lat);
      check("rd_data",  rd,       64'h1122334455667788);
      check("rd_err",   64'(er),  64'd0);
      check("rd_lat",   64'(lat), 64'd3);

      // partial write
      xact(1'b1, 64'h8000_0010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, rd, er, lat);
      check("pw_err", 64'(er), 64'd0);
      xact(1'b0, 64'h8000_0010, 64'h0, 8'h00, rd, er, lat);
      check("pw_data", rd, 64'h11223344AAAAAAAA);

      // zero mask is a no-op
      xact(1'b1, 64'h8000_0010, 64'hFFFFFFFFFFFFFFFF, 8'h00, rd, er, lat);
      check("m0_err", 64'(er), 64'd0);
      xact(1'b0, 64'h8000_0010, 64'h0, 8'h00, rd, er, lat);
      check("m0_data", rd, 64'h11223344AAAAAAAA);

      // address errors and range boundaries
      xact(1'b1, 64'h8000_0000, 64'h0123456789ABCDEF, 8'hFF, rd, er, lat);
      xact(1'b1, 64'h8000_07F8, 64'h0F0E0D0C0B0A0908, 8'hFF, rd, er, lat);
      check("last_wr_err", 64'(er), 64'd0);
      xact(1'b0, 64'h8000_07F8, 64'h0, 8'h00, rd, er, lat);
      check("last_rd_data", rd, 64'h0F0E0D0C0B0A0908);
      check("last_rd_err",  64'(er), 64'd0);
      xact(1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, rd, er, lat);
      check("below_err",  64'(er), 64'd1);
      check("below_data", rd, 64'd0);
      xact(1'b0, 64'h8000_0800, 64'h0, 8'h00, rd, er, lat);
      check("above_err",  64'(er), 64'd1);
      check("above_data", rd, 64'd0);
      xact(1'b1, 64'h8000_0004, 64'hFEDCBA9876543210, 8'hFF, rd, er, lat);
      check("misal_err",  64'(er), 64'd1);
      check("misal_data", rd, 64'd0);
      xact(1'b1, 64'h8000_0800, 64'hFEDCBA9876543210, 8'hFF, rd, er, lat);
      check("oor_wr_err", 64'(er), 64'd1);
      xact(1'b0, 64'h8000_0000, 64'h0, 8'h00, rd, er, lat);
      check("err_nochg", rd, 64'h0123456789ABCDEF);

      // backpressure
      xact(1'b1, 64'h8000_0008, 64'h0BADF00D12345678, 8'hFF, rd, er, lat);
      resp_ready = 1'b0;
      xact(1'b0, 64'h8000_0008, 64'h0, 8'h00, rd, er, lat);
      check("bp_first", rd, 64'h0BADF00D12345678);
      req_wen = 1'b1; req_addr = 64'h8000_0008; req_wdata = 64'h5A5A5A5A5A5A5A5A; req_wmask = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         req_valid = (i == 2);
         check("bp_valid", 64'(resp_valid), 64'd1);
         check("bp_rdata", resp_rdata, 64'h0BADF00D12345678);
         check("bp_ready", 64'(req_ready), 64'd0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release", 64'(resp_valid), 64'd0);
      check("bp_idle",    64'(req_ready),  64'd1);
      xact(1'b0, 64'h8000_0008, 64'h0, 8'h00, rd, er, lat);
      check("bp_noaccept", rd, 64'h0BADF00D12345678);

      // reset while waiting
      xact(1'b1, 64'h8000_0020, 64'h0000000000005555, 8'hFF, rd, er, lat);
      req_wen = 1'b1; req_addr = 64'h8000_0020; req_wdata = 64'h000000000000DEAD; req_wmask = 8'hFF;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstw_ready", 64'(req_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         seen = seen | resp_valid;
         @(posedge clk); #1;
      end
      check("rstw_noresp", 64'(seen), 64'd0);
      xact(1'b0, 64'h8000_0020, 64'h0, 8'h00, rd, er, lat);
      check("rstw_data", rd, 64'h0000000000005555);

      // zero latency, back to back
      op_wen[0] = 1'b1; op_addr[0] = 64'h8000_0000; op_wdata[0] = 64'hCAFE; op_exp[0] = 64'd0;
      op_wen[1] = 1'b1; op_addr[1] = 64'h8000_0008; op_wdata[1] = 64'hBEEF; op_exp[1] = 64'd0;
      op_wen[2] = 1'b0; op_addr[2] = 64'h8000_0000; op_wdata[2] = 64'd0;    op_exp[2] = 64'hCAFE;
      op_wen[3] = 1'b0; op_addr[3] = 64'h8000_0008; op_wdata[3] = 64'd0;    op_exp[3] = 64'hBEEF;
      begin
         int k;
         int cyc;
         logic took;
         k = 0;
         cyc = 0;
         req_wen0 = op_wen[0]; req_addr0 = op_addr[0]; req_wdata0 = op_wdata[0]; req_wmask0 = 8'hFF;
         req_valid0 = 1'b1;
         while (k < 4 && cyc < 40) begin
            took = req_ready0;
            @(posedge clk); #1;
            cyc++;
            if (took) begin
               check("l0_valid", 64'(resp_valid0), 64'd1);
               check("l0_rdata", resp_rdata0, op_exp[k]);
               check("l0_err",   64'(resp_err0), 64'd0);
               k++;
               if (k < 4) begin
                  req_wen0 = op_wen[k]; req_addr0 = op_addr[k]; req_wdata0 = op_wdata[k];
               end else begin
                  req_valid0 = 1'b0;
               end
            end
         end
         check("l0_cycles", 64'(cyc), 64'd7);
         @(posedge clk); #1;
         check("l0_idle", 64'(req_ready0), 64'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
